// File: rtl/matvec_share_arb.sv
// matvec_share_arb: shares one matvec engine between two clients.
// Grants whole jobs round-robin; an owner-tag FIFO routes results back.
module matvec_share_arb #(
  parameter int DW        = 14,
  parameter int OW        = 28,
  parameter int N         = 8,
  parameter int TAG_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    in_valid,
  output logic [1:0]    in_ready,
  input  logic [DW-1:0] in_data0,
  input  logic [DW-1:0] in_data1,
  input  logic [1:0]    in_new_matrix,
  output logic [1:0]    out_valid,
  input  logic [1:0]    out_ready,
  output logic [OW-1:0] out_data,
  output logic          m_input_valid,
  input  logic          m_input_ready,
  output logic [DW-1:0] m_input_data,
  output logic          m_new_matrix,
  input  logic          m_output_valid,
  output logic          m_output_ready,
  input  logic [OW-1:0] m_output_data,
  output logic          err_stale
);
  localparam int WCW = $clog2(N*N+N);
  localparam int OCW = (N > 1) ? $clog2(N) : 1;
  localparam int PW  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW  = $clog2(TAG_DEPTH+1);
  localparam logic [WCW-1:0] MAT_LAST = WCW'(N*N+N-1);
  localparam logic [WCW-1:0] VEC_LAST = WCW'(N-1);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(N-1);
  localparam logic [PW-1:0]  PTR_LAST = PW'(TAG_DEPTH-1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(TAG_DEPTH);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state_q;
  logic                 owner_q;
  logic                 rr_q;
  logic                 mat_q;
  logic [WCW-1:0]       wcnt_q, wcnt_d;
  logic                 lowner_q;
  logic                 lvalid_q;
  logic                 err_q;
  logic [TAG_DEPTH-1:0] tag_q;
  logic [PW-1:0]        wr_q, rd_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OCW-1:0]       ocnt_q;

  logic full, empty, head;
  logic grant_en, grant_g;
  logic in_acc, last_word;
  logic out_acc, pop;

  assign full      = (cnt_q == CNT_FULL);
  assign empty     = (cnt_q == '0);
  assign head      = tag_q[rd_q];
  assign grant_en  = (state_q == IDLE) && (|in_valid) && !full;
  assign grant_g   = in_valid[rr_q] ? rr_q : ~rr_q;
  assign in_acc    = (state_q == BUSY) && m_input_valid && m_input_ready;
  assign last_word = (wcnt_q == (mat_q ? MAT_LAST : VEC_LAST));
  assign out_acc   = m_output_valid && m_output_ready;
  assign pop       = out_acc && (ocnt_q == OUT_LAST);
  assign out_data  = m_output_data;
  assign err_stale = err_q;

  // Steer the granted client onto the engine input for the whole job.
  always_comb begin
    in_ready      = '0;
    m_input_valid = 1'b0;
    m_input_data  = '0;
    m_new_matrix  = 1'b0;
    if (state_q == BUSY) begin
      m_input_valid     = in_valid[owner_q];
      m_input_data      = owner_q ? in_data1 : in_data0;
      in_ready[owner_q] = m_input_ready;
      m_new_matrix      = (wcnt_q == '0) && in_new_matrix[owner_q];
    end
  end

  // Route engine results to the client at the head of the tag FIFO.
  always_comb begin
    out_valid      = '0;
    m_output_ready = 1'b0;
    if (!empty) begin
      out_valid[head] = m_output_valid;
      m_output_ready  = out_ready[head];
    end
  end

  // Next word count and tag occupancy.
  always_comb begin
    wcnt_d = wcnt_q;
    if (in_acc) wcnt_d = last_word ? '0 : wcnt_q + WCW'(1);
    unique case ({grant_en, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Job FSM: round-robin grant, job length latch, matrix ownership.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      mat_q    <= 1'b0;
      wcnt_q   <= '0;
      lowner_q <= 1'b0;
      lvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      unique case (state_q)
        IDLE: begin
          if (grant_en) begin
            state_q <= BUSY;
            owner_q <= grant_g;
            rr_q    <= ~grant_g;
            mat_q   <= in_new_matrix[grant_g];
            if (in_new_matrix[grant_g]) begin
              lowner_q <= grant_g;
              lvalid_q <= 1'b1;
            end else if (!lvalid_q || lowner_q != grant_g) begin
              err_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (in_acc && last_word) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Owner-tag FIFO and per-vector output word counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ocnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (grant_en) begin
        tag_q[wr_q] <= grant_g;
        wr_q <= (wr_q == PTR_LAST) ? '0 : wr_q + PW'(1);
      end
      if (out_acc) ocnt_q <= pop ? '0 : ocnt_q + OCW'(1);
      if (pop) rd_q <= (rd_q == PTR_LAST) ? '0 : rd_q + PW'(1);
    end
  end
endmodule

// File: tb/tb_matvec_share_arb.sv
// Bench for matvec_share_arb: engine stub, job-level reference model,
// randomized two-client traffic plus directed arbitration/stall/reset cases.
`timescale 1ns/1ps
module tb_matvec_share_arb;
  localparam int DW = 14;
  localparam int OW = 28;
  localparam int N  = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] in_valid, in_ready, in_new_matrix;
  logic [1:0] out_valid, out_ready;
  logic [DW-1:0] in_data0, in_data1, m_input_data;
  logic [OW-1:0] out_data, m_output_data;
  logic m_input_valid, m_input_ready, m_new_matrix;
  logic m_output_valid, m_output_ready, err_stale;

  logic iv [2];
  logic nmv [2];
  logic [DW-1:0] dd [2];
  logic hold_or = 1'b0;

  assign in_valid = {iv[1], iv[0]};
  assign in_new_matrix = {nmv[1], nmv[0]};
  assign in_data0 = dd[0];
  assign in_data1 = dd[1];

  always #5 clk = ~clk;

  matvec_share_arb dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data0(in_data0), .in_data1(in_data1),
    .in_new_matrix(in_new_matrix),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
    .m_input_valid(m_input_valid),
    .m_input_ready(m_input_ready),
    .m_input_data(m_input_data),
    .m_new_matrix(m_new_matrix),
    .m_output_valid(m_output_valid),
    .m_output_ready(m_output_ready),
    .m_output_data(m_output_data),
    .err_stale(err_stale)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  int cur_c = -1;
  int rem = 0;
  int widx = 0;
  bit cur_nm = 0;
  int pmat [64];
  int mmat [64];
  int vec [8];
  bit m_valid = 0;
  int m_owner = 0;
  bit exp_err = 0;
  int expq0 [$];
  int expq1 [$];
  int got0 [$];
  int got1 [$];
  int order [$];
  int start_acc [$];
  int out_acc_cnt = 0;

  int row0 [8] = '{10, -20, 30, -40, 50, -60, 70, 80};
  int row7 [8] = '{-78, 112, -98, 132, 28, -52, 9, 14};
  int v1 [8] = '{-50, 40, 32, -16, 11, -49, 49, 111};
  int v2 [8] = '{22, -41, 42, 62, 4, -55, 7, -8};

  // Engine stub: loads 64 matrix words then 8 vector words,
  // or 8 vector words alone; emits y = M*v row by row.
  initial begin
    bit ai, ao, anm, emode;
    int ad, ecnt, s;
    int emat [64];
    int evec [8];
    int eq [$];
    ecnt = 0;
    emode = 0;
    foreach (emat[k]) emat[k] = 0;
    m_input_ready = 1'b0;
    m_output_valid = 1'b0;
    m_output_data = '0;
    forever begin
      @(negedge clk);
      ai = m_input_valid && m_input_ready;
      ao = m_output_valid && m_output_ready;
      ad = $signed(m_input_data);
      anm = m_new_matrix;
      @(posedge clk);
      #1;
      if (!reset) begin
        ecnt = 0;
        eq.delete();
        foreach (emat[k]) emat[k] = 0;
        m_input_ready = 1'b0;
        m_output_valid = 1'b0;
        m_output_data = '0;
      end else begin
        if (ao) void'(eq.pop_front());
        if (ai) begin
          if (ecnt == 0) emode = anm;
          if (emode && ecnt < 64) emat[ecnt] = ad;
          else evec[emode ? ecnt - 64 : ecnt] = ad;
          ecnt++;
          if (ecnt == (emode ? 72 : 8)) begin
            ecnt = 0;
            for (int i = 0; i < 8; i++) begin
              s = 0;
              for (int j = 0; j < 8; j++)
                s += emat[i*8+j] * evec[j];
              eq.push_back(s);
            end
          end
        end
        m_input_ready = ($urandom_range(99) < 75);
        m_output_valid = (eq.size() > 0) &&
                         ($urandom_range(99) < 75);
        m_output_data = (eq.size() > 0) ? OW'(eq[0]) : '0;
      end
    end
  end

  // Random result backpressure, forced low while hold_or is set.
  initial begin
    out_ready = '0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_or) out_ready = '0;
      else out_ready = {($urandom_range(99) < 70),
                        ($urandom_range(99) < 70)};
    end
  end

  // Compare process: job-level model checked every cycle.
  initial begin
    bit a0, a1, macc, o0, o1, mo;
    int c, w, s, e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cur_c = -1;
        rem = 0;
        m_valid = 0;
        exp_err = 0;
        expq0.delete();
        expq1.delete();
        foreach (mmat[k]) mmat[k] = 0;
      end else begin
        a0 = in_valid[0] && in_ready[0];
        a1 = in_valid[1] && in_ready[1];
        macc = m_input_valid && m_input_ready;
        chk("in_ready_onehot", in_ready[0] && in_ready[1], 0);
        chk("m_in_hs", macc, a0 || a1);
        if (a0 || a1) begin
          c = a0 ? 0 : 1;
          w = c ? $signed(in_data1) : $signed(in_data0);
          chk("m_in_data", $signed(m_input_data), w);
          if (rem == 0) begin
            cur_c = c;
            cur_nm = in_new_matrix[c];
            rem = cur_nm ? N*N+N : N;
            widx = 0;
            order.push_back(c);
            start_acc.push_back(out_acc_cnt);
            if (cur_nm) begin
              m_owner = c;
              m_valid = 1;
            end else if (!m_valid || m_owner != c) begin
              exp_err = 1;
            end
            chk("m_new_matrix_first", m_new_matrix, cur_nm);
            chk("err_stale", err_stale, exp_err);
          end else begin
            chk("job_owner", c, cur_c);
            chk("m_new_matrix_later", m_new_matrix, 0);
          end
          if (cur_nm && widx < 64) pmat[widx] = w;
          else vec[cur_nm ? widx - 64 : widx] = w;
          widx++;
          rem--;
          if (rem == 0) begin
            if (cur_nm) mmat = pmat;
            for (int i = 0; i < 8; i++) begin
              s = 0;
              for (int j = 0; j < 8; j++)
                s += mmat[i*8+j] * vec[j];
              if (cur_c == 0) expq0.push_back(s);
              else expq1.push_back(s);
            end
          end
        end
        o0 = out_valid[0] && out_ready[0];
        o1 = out_valid[1] && out_ready[1];
        mo = m_output_valid && m_output_ready;
        chk("out_valid_onehot", out_valid[0] && out_valid[1], 0);
        chk("m_out_hs", mo, o0 || o1);
        chk("c0_valid_pending", out_valid[0] && expq0.size() == 0, 0);
        chk("c1_valid_pending", out_valid[1] && expq1.size() == 0, 0);
        if (o0 && expq0.size() > 0) begin
          e = expq0.pop_front();
          got0.push_back($signed(out_data));
          chk("c0_data", $signed(out_data), e);
        end
        if (o1 && expq1.size() > 0) begin
          e = expq1.pop_front();
          got1.push_back($signed(out_data));
          chk("c1_data", $signed(out_data), e);
        end
        if (o0 || o1) out_acc_cnt++;
      end
    end
  end

  // Present one job word by word; stop early after stop_at accepts.
  task automatic drive_job(input int c, input bit nm,
                           input int words[$], input int gap,
                           input int stop_at);
    int i, cyc;
    bit acc;
    i = 0;
    cyc = 0;
    while (i < words.size() && i != stop_at && cyc < 3000) begin
      iv[c] = ($urandom_range(99) >= gap);
      dd[c] = DW'(words[i]);
      nmv[c] = (i == 0) ? nm : 1'($urandom_range(1));
      @(negedge clk);
      acc = iv[c] && in_ready[c];
      @(posedge clk);
      #1;
      if (acc) i++;
      cyc++;
    end
    iv[c] = 1'b0;
    nmv[c] = 1'b0;
    if (i != stop_at) chk("drive_done", i, words.size());
  endtask

  function automatic int rnd_w();
    return int'($urandom_range(4000)) - 2000;
  endfunction

  task automatic send_rand(input int c, input bit nm, input int gap);
    int w [$];
    for (int k = 0; k < (nm ? N*N+N : N); k++) w.push_back(rnd_w());
    drive_job(c, nm, w, gap, -1);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((expq0.size() + expq1.size() != 0 || rem != 0) && k < 5000) begin
      @(posedge clk);
      k++;
    end
    chk("drain_in_time", k < 5000, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w [$];
    int base, acc0, rel, g1;
    iv[0] = 0; iv[1] = 0;
    nmv[0] = 0; nmv[1] = 0;
    dd[0] = '0; dd[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_m_in_valid", m_input_valid, 0);
    chk("rst_m_out_ready", m_output_ready, 0);
    chk("rst_err", err_stale, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Client 0 matrix job with pinned first/last rows
    w.delete();
    for (int k = 0; k < 8; k++) w.push_back(row0[k]);
    for (int k = 0; k < 48; k++) w.push_back(rnd_w());
    for (int k = 0; k < 8; k++) w.push_back(row7[k]);
    for (int k = 0; k < 8; k++) w.push_back(v1[k]);
    drive_job(0, 1, w, 30, -1);
    wait_drain();
    chk("t1_count", got0.size(), 8);
    chk("t1_y0", got0[0], 16100);
    chk("t1_y7", got0[7], 7983);
    chk("t1_c1_none", got1.size(), 0);
    chk("t1_err", err_stale, 0);

    // Client 0 vector job reusing its matrix
    w.delete();
    for (int k = 0; k < 8; k++) w.push_back(v2[k]);
    drive_job(0, 0, w, 30, -1);
    wait_drain();
    chk("t2_count", got0.size(), 16);
    chk("t2_y0", got0[8], 3170);
    chk("t2_y7", got0[15], 683);
    chk("t2_err", err_stale, 0);

    // Client 1 vector job against client 0's matrix
    fork
      send_rand(1, 0, 0);
      begin
        @(negedge clk);
        chk("err_pre_grant", err_stale, 0);
        @(negedge clk);
        chk("err_post_grant", err_stale, 1);
      end
    join
    wait_drain();
    chk("t4_c1_count", got1.size(), 8);
    chk("t4_err_sticky", err_stale, 1);

    // Simultaneous requests right after reset: strict alternation
    pulse_reset();
    chk("t3_err_cleared", err_stale, 0);
    base = order.size();
    fork
      begin send_rand(0, 1, 0); send_rand(0, 1, 0); end
      begin send_rand(1, 1, 0); send_rand(1, 1, 0); end
    join
    wait_drain();
    chk("t3_jobs", order.size() - base, 4);
    chk("t3_g0", order[base], 0);
    chk("t3_g1", order[base+1], 1);
    chk("t3_g2", order[base+2], 0);
    chk("t3_g3", order[base+3], 1);

    // Random mixed traffic from both clients
    fork
      for (int k = 0; k < 12; k++)
        send_rand(0, ($urandom_range(3) == 0),
                  int'($urandom_range(50)));
      for (int k = 0; k < 12; k++)
        send_rand(1, ($urandom_range(3) == 0),
                  int'($urandom_range(50)));
    join
    wait_drain();

    // Tag FIFO full: fifth job waits until a result vector drains
    hold_or = 1'b1;
    @(posedge clk);
    #1;
    base = order.size();
    acc0 = out_acc_cnt;
    for (int k = 0; k < 4; k++) send_rand(0, 0, 0);
    chk("t5_four_granted", order.size() - base, 4);
    rel = 0;
    fork
      send_rand(0, 0, 0);
      begin
        repeat (20) begin
          @(negedge clk);
          chk("t5_full_in_ready", in_ready[0], 0);
        end
        chk("t5_no_drain", out_acc_cnt - acc0, 0);
        chk("t5_fifth_waits", order.size() - base, 4);
        rel = out_acc_cnt;
        @(posedge clk);
        #1;
        hold_or = 1'b0;
      end
    join
    chk("t5_fifth_after_pop",
        start_acc[start_acc.size()-1] - rel >= 8, 1);
    wait_drain();
    chk("t5_total_drained", out_acc_cnt - acc0, 40);

    // Reset at word 30 of a matrix job
    w.delete();
    for (int k = 0; k < 72; k++) w.push_back(rnd_w());
    drive_job(0, 1, w, 0, 30);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_in_ready", in_ready, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_m_in_valid", m_input_valid, 0);
    chk("t6_m_out_ready", m_output_ready, 0);
    chk("t6_err", err_stale, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    g1 = got1.size();
    send_rand(1, 1, 20);
    wait_drain();
    chk("t6_c1_count", got1.size() - g1, 8);
    chk("t6_err_after", err_stale, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
